// File: rtl/rx_packet_parser.sv
// Receive-side packet parser: hunts for SOF, validates length and XOR checksum,
// buffers the payload and releases only clean packets over a valid/ready stream.
module rx_packet_parser #(
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic [2:0] rx_error,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] pkt_len,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       drop,
    output logic       busy
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d, idx_q, idx_d, rd_q, rd_d;
    logic [7:0]    xor_q, xor_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d, drop_q, drop_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    mem_q [0:MAX_LEN-1];
    logic          buf_we, abort, line_err, tmo, last_rd;
    logic [1:0]    abort_code;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_HUNT;
            len_q      <= '0;
            idx_q      <= '0;
            rd_q       <= '0;
            xor_q      <= 8'd0;
            tmr_q      <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            drop_q     <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_q       <= rd_d;
            xor_q      <= xor_d;
            tmr_q      <= tmr_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            drop_q     <= drop_d;
            err_code_q <= err_code_d;
        end
    end

    // Payload storage needs no reset: it is only read in DRAIN, after being written.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            mem_q[idx_q[AW-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rd_d       = rd_q;
        xor_d      = xor_q;
        tmr_d      = tmr_q;
        err_code_d = err_code_q;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        drop_d     = 1'b0;
        buf_we     = 1'b0;
        abort      = 1'b0;
        abort_code = 2'd0;
        line_err   = rx_valid && (rx_error != 3'd0);
        // An arriving byte always beats an expiring timer.
        tmo        = !rx_valid && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
        last_rd    = (rd_q == len_q - IW'(1));
        case (state_q)
            S_HUNT: begin
                tmr_d = '0;
                if (rx_valid && (rx_error == 3'd0) && (rx_byte == SOF)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN, S_PAYLOAD, S_CHECK: begin
                tmr_d = rx_valid ? '0 : tmr_q + TW'(1);
                if (line_err) begin
                    abort      = 1'b1;
                    abort_code = 2'd3;
                end else if (tmo) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end else if (rx_valid) begin
                    if (state_q == S_LEN) begin
                        if ((rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN))) begin
                            abort      = 1'b1;
                            abort_code = 2'd0;
                        end else begin
                            len_d   = rx_byte[IW-1:0];
                            xor_d   = rx_byte;
                            idx_d   = '0;
                            state_d = S_PAYLOAD;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        buf_we = 1'b1;
                        xor_d  = xor_q ^ rx_byte;
                        idx_d  = idx_q + IW'(1);
                        if (idx_q + IW'(1) == len_q) begin
                            state_d = S_CHECK;
                        end
                    end else if (rx_byte == xor_q) begin
                        pkt_ok_d = 1'b1;
                        rd_d     = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        abort      = 1'b1;
                        abort_code = 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                drop_d = rx_valid;
                if (out_ready) begin
                    if (last_rd) begin
                        state_d = S_HUNT;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
        if (abort) begin
            state_d    = S_HUNT;
            pkt_err_d  = 1'b1;
            err_code_d = abort_code;
            tmr_d      = '0;
        end
    end

    always_comb begin
        out_valid = (state_q == S_DRAIN);
        out_last  = out_valid && last_rd;
        out_data  = out_valid ? mem_q[rd_q[AW-1:0]] : 8'd0;
        pkt_len   = out_valid ? 8'(len_q) : 8'd0;
        busy      = (state_q != S_HUNT);
        pkt_ok    = pkt_ok_q;
        pkt_err   = pkt_err_q;
        err_code  = err_code_q;
        drop      = drop_q;
    end
endmodule

// File: tb/tb_rx_packet_parser.sv
// Bench for rx_packet_parser: directed frames plus random packet mix, all checked
// against a packet-level model of expected payload bytes and ok/err events.
module tb_rx_packet_parser;
    localparam int T    = 20;
    localparam int MAXL = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'd0;
    logic       rx_valid = 1'b0;
    logic [2:0] rx_error = 3'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic [7:0] pkt_len;
    logic       pkt_ok, pkt_err, drop, busy;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    int drops_seen = 0;
    logic rand_ready = 1'b0;
    logic ready_force = 1'b0;

    // Model state: expected payload stream and expected event sequence (4 = ok, 0..3 = err_code).
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [7:0] exp_len_q[$];
    int         ev_q[$];
    logic [7:0] tx_q[$];
    logic [2:0] txe_q[$];

    rx_packet_parser #(.SOF(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_error(rx_error), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .pkt_len(pkt_len),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .drop(drop), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        int obs_ev;
        int exp_ev;
        if (!reset) begin
            if (drop) drops_seen++;
            if (out_valid && exp_q.size() == 0) check_val("spurious_valid", 32'(out_valid), 0);
            if (out_valid && exp_q.size() != 0) begin
                check_val("out_data", 32'(out_data), 32'(exp_q[0]));
                check_val("out_last", 32'(out_last), 32'(exp_last_q[0]));
                check_val("pkt_len", 32'(pkt_len), 32'(exp_len_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                    void'(exp_len_q.pop_front());
                end
            end
            if (!out_valid) check_val("pkt_len_idle", 32'(pkt_len), 0);
            if (pkt_ok || pkt_err) begin
                obs_ev = pkt_ok ? 4 : int'(err_code);
                exp_ev = (ev_q.size() != 0) ? ev_q.pop_front() : 7;
                check_val("event", 32'(obs_ev), 32'(exp_ev));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [2:0] e);
        rx_byte  = b;
        rx_error = e;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_error = 3'd0;
    endtask

    task automatic send_all(input int gap_max);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], txe_q[i]);
            if (i != tx_q.size() - 1) idle($urandom_range(0, gap_max));
        end
        tx_q.delete();
        txe_q.delete();
    endtask

    task automatic push_tx(input logic [7:0] b, input logic [2:0] e);
        tx_q.push_back(b);
        txe_q.push_back(e);
    endtask

    // Builds SOF, LEN, payload, CHK; optionally records the payload as expected output.
    task automatic build_frame(input int len, input bit keep, input bit bad_chk);
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] p[$];
        push_tx(8'hA5, 3'd0);
        push_tx(8'(len), 3'd0);
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            p.push_back(b);
            push_tx(b, 3'd0);
            x = x ^ b;
        end
        if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
        push_tx(x, 3'd0);
        if (keep) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(p[i]);
                exp_last_q.push_back(i == len - 1);
                exp_len_q.push_back(8'(len));
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            idle(1);
            n++;
        end
        if (busy) check_val("busy_bound", 32'(busy), 0);
        idle(1);
        check_val("drained", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 60) begin
            idle(1);
            n++;
        end
        check_val("valid_bound", 32'(out_valid), 1);
    endtask

    initial begin
        int kind;
        int len;
        int pos;
        int drops_before;
        logic [7:0] jb;
        logic [2:0] je;

        idle(3);
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_data", 32'(out_data), 0);
        check_val("rst_pulses", 32'({pkt_ok, pkt_err, drop, out_last}), 0);
        check_val("rst_err_code", 32'(err_code), 0);
        check_val("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        idle(2);

        // Good packet with exact first-drain-cycle timing.
        ready_force = 1'b1;
        idle(1);
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        txe_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_q = '{8'h11, 8'h22, 8'h33};
        exp_last_q = '{1'b0, 1'b0, 1'b1};
        exp_len_q = '{8'd3, 8'd3, 8'd3};
        ev_q.push_back(4);
        send_all(0);
        check_val("chk_pkt_ok", 32'(pkt_ok), 1);
        check_val("chk_out_valid", 32'(out_valid), 1);
        check_val("chk_first_byte", 32'(out_data), 32'h11);
        check_val("chk_pkt_len", 32'(pkt_len), 3);
        wait_idle();
        check_val("busy_after_good", 32'(busy), 0);

        // Junk (including an errored SOF) then a stalled one-byte packet.
        ready_force = 1'b0;
        idle(1);
        tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        txe_q = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_q.push_back(8'h7E);
        exp_last_q.push_back(1'b1);
        exp_len_q.push_back(8'd1);
        ev_q.push_back(4);
        send_all(0);
        idle(5);
        check_val("stall_hold_valid", 32'(out_valid), 1);
        check_val("stall_hold_data", 32'(out_data), 32'h7E);
        ready_force = 1'b1;
        wait_idle();

        // Bad checksum, bad lengths, then a good packet.
        tx_q = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        txe_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        ev_q.push_back(1);
        send_all(0);
        idle(1);
        check_val("badchk_code", 32'(err_code), 1);
        wait_idle();
        tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h42, 8'h43};
        txe_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        ev_q.push_back(0);
        ev_q.push_back(0);
        ev_q.push_back(4);
        exp_q.push_back(8'h42);
        exp_last_q.push_back(1'b1);
        exp_len_q.push_back(8'd1);
        send_all(0);
        wait_idle();

        // Timeout after exactly T silent cycles, and a byte on the expiry cycle.
        send_byte(8'hA5, 3'd0);
        send_byte(8'h02, 3'd0);
        send_byte(8'h10, 3'd0);
        idle(T - 1);
        check_val("pre_timeout_busy", 32'(busy), 1);
        check_val("pre_timeout_err", 32'(pkt_err), 0);
        ev_q.push_back(2);
        idle(1);
        check_val("timeout_err", 32'(pkt_err), 1);
        check_val("timeout_code", 32'(err_code), 2);
        wait_idle();
        send_byte(8'hA5, 3'd0);
        send_byte(8'h02, 3'd0);
        send_byte(8'h10, 3'd0);
        idle(T - 1);
        ev_q.push_back(4);
        exp_q.push_back(8'h10);
        exp_last_q.push_back(1'b0);
        exp_len_q.push_back(8'd2);
        exp_q.push_back(8'h20);
        exp_last_q.push_back(1'b1);
        exp_len_q.push_back(8'd2);
        send_byte(8'h20, 3'd0);
        send_byte(8'h32, 3'd0);
        wait_idle();

        // Line error on a payload byte.
        tx_q = '{8'hA5, 8'h02, 8'h10};
        txe_q = '{3'd0, 3'd0, 3'd1};
        ev_q.push_back(3);
        send_all(0);
        idle(1);
        check_val("line_err_code", 32'(err_code), 3);
        wait_idle();

        // Bytes arriving during a stalled drain are dropped.
        ready_force = 1'b0;
        tx_q = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
        txe_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_q = '{8'hC3, 8'h3C};
        exp_last_q = '{1'b0, 1'b1};
        exp_len_q = '{8'd2, 8'd2};
        ev_q.push_back(4);
        send_all(0);
        wait_valid();
        drops_before = drops_seen;
        send_byte(8'hA5, 3'd0);
        send_byte(8'h01, 3'd0);
        send_byte(8'h99, 3'd0);
        idle(1);
        check_val("drop_count", 32'(drops_seen - drops_before), 3);
        ready_force = 1'b1;
        wait_idle();

        // Reset during drain.
        ready_force = 1'b0;
        tx_q = '{8'hA5, 8'h01, 8'h55, 8'h54};
        txe_q = '{3'd0, 3'd0, 3'd0, 3'd0};
        exp_q = '{8'h55};
        exp_last_q = '{1'b1};
        exp_len_q = '{8'd1};
        ev_q.push_back(4);
        send_all(0);
        wait_valid();
        idle(1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_last_q.delete();
        exp_len_q.delete();
        check_val("rst_drain_valid", 32'(out_valid), 0);
        check_val("rst_drain_busy", 32'(busy), 0);
        check_val("rst_drain_len", 32'(pkt_len), 0);
        check_val("rst_drain_code", 32'(err_code), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);
        check_val("post_rst_valid", 32'(out_valid), 0);

        // Random packet mix with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < $urandom_range(0, 3); j++) begin
                jb = 8'($urandom);
                je = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                if (jb == 8'hA5 && je == 3'd0) jb = 8'h00;
                push_tx(jb, je);
            end
            kind = $urandom_range(0, 6);
            len = $urandom_range(1, MAXL);
            if (kind <= 3) begin
                build_frame(len, 1'b1, 1'b0);
                ev_q.push_back(4);
            end else if (kind == 4) begin
                build_frame(len, 1'b0, 1'b1);
                ev_q.push_back(1);
            end else if (kind == 5) begin
                push_tx(8'hA5, 3'd0);
                push_tx(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255)), 3'd0);
                ev_q.push_back(0);
            end else begin
                build_frame(len, 1'b0, 1'b0);
                pos = tx_q.size() - len - 2 + $urandom_range(1, len + 2) - 1;
                pos = (pos < tx_q.size() - len - 1) ? tx_q.size() - len - 1 : pos;
                txe_q[pos] = 3'($urandom_range(1, 7));
                while (tx_q.size() > pos + 1) begin
                    void'(tx_q.pop_back());
                    void'(txe_q.pop_back());
                end
                ev_q.push_back(3);
            end
            send_all(3);
            wait_idle();
        end

        idle(4);
        check_val("events_left", 32'(ev_q.size()), 0);
        check_val("bytes_left", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
